// File: rtl/inf_pkg.sv
// inf_pkg: shared definitions for the INF neuron array.
//   state_e             readout FSM states (IDLE / SCAN / DONE)
//   N_CH_DEF, MEM_W_DEF, W_W_DEF   default geometry
//   MEM_MAX, MEM_MIN    signed membrane extremes at the default width
package inf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int N_CH_DEF  = 20;
  localparam int MEM_W_DEF = 16;
  localparam int W_W_DEF   = 8;

  localparam logic [MEM_W_DEF-1:0] MEM_MAX = {1'b0, {(MEM_W_DEF-1){1'b1}}};
  localparam logic [MEM_W_DEF-1:0] MEM_MIN = {1'b1, {(MEM_W_DEF-1){1'b0}}};

endpackage

// File: rtl/inf_accum.sv
// inf_accum: combinational membrane update for one weight event.
// Sign-extends the weight, adds it to the membrane, flags signed overflow.
// Build option INF_SAT_EN: clamp an overflowing sum to the signed extreme;
// without it the sum wraps modulo 2^MEM_W. ovf_o is the same in both builds.
//   mem_i     current membrane (signed)
//   weight_i  event weight (signed)
//   sum_o     updated membrane
//   ovf_o     signed overflow of this add
module inf_accum
  import inf_pkg::*;
#(
  parameter int MEM_W = MEM_W_DEF,
  parameter int W_W   = W_W_DEF
) (
  input  logic [MEM_W-1:0] mem_i,
  input  logic [W_W-1:0]   weight_i,
  output logic [MEM_W-1:0] sum_o,
  output logic             ovf_o
);

  logic [MEM_W-1:0] w_ext;
  logic [MEM_W-1:0] raw;

  assign w_ext = {{(MEM_W-W_W){weight_i[W_W-1]}}, weight_i};
  assign raw   = mem_i + w_ext;
  // Overflow only possible when both operands share a sign.
  assign ovf_o = (mem_i[MEM_W-1] == w_ext[MEM_W-1]) && (raw[MEM_W-1] != mem_i[MEM_W-1]);

`ifdef INF_SAT_EN
  localparam logic [MEM_W-1:0] SAT_MAX = {1'b0, {(MEM_W-1){1'b1}}};
  localparam logic [MEM_W-1:0] SAT_MIN = {1'b1, {(MEM_W-1){1'b0}}};
  assign sum_o = ovf_o ? (mem_i[MEM_W-1] ? SAT_MIN : SAT_MAX) : raw;
`else
  assign sum_o = raw;
`endif

endmodule

// File: rtl/inf_neuron_array.sv
// inf_neuron_array: bank of N_CH integrate-no-fire output neurons.
// Weight events accumulate into registered membranes; a scan streams all
// membranes out and reports the signed arg-max (ties to lowest index).
// Build option INF_SAT_EN (see inf_accum): saturating instead of wrapping adds.
//   clk, rst_n            clock, async active-low reset
//   clr                   zero membranes/overflow mask, abort scan
//   acc_valid/ready/ch/weight   weight event stream
//   scan_start, busy      readout request / in progress
//   out_valid/ch/mem      one membrane per beat during scan
//   win_valid/ch/mem      winner pulse and held winner
//   of_mask               sticky per-channel overflow flags
//
// state   | meaning
// IDLE    | accepting events, waiting for scan_start
// SCAN    | emitting one channel per cycle, tracking running max
// DONE    | winner pulse, back to IDLE next cycle
module inf_neuron_array
  import inf_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int MEM_W = MEM_W_DEF,
  parameter int W_W   = W_W_DEF,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             acc_valid,
  output logic             acc_ready,
  input  logic [CH_W-1:0]  acc_ch,
  input  logic [W_W-1:0]   acc_weight,
  input  logic             scan_start,
  output logic             busy,
  output logic             out_valid,
  output logic [CH_W-1:0]  out_ch,
  output logic [MEM_W-1:0] out_mem,
  output logic             win_valid,
  output logic [CH_W-1:0]  win_ch,
  output logic [MEM_W-1:0] win_mem,
  output logic [N_CH-1:0]  of_mask
);

  state_e           state_q, state_d;
  logic [MEM_W-1:0] mem_q [N_CH];
  logic [N_CH-1:0]  of_q;
  logic             busy_q, out_valid_q, win_valid_q;
  logic [CH_W-1:0]  out_ch_q, win_ch_q, best_ch_q;
  logic [MEM_W-1:0] out_mem_q, win_mem_q, best_mem_q;

  logic             ch_ok, wr_en, last_beat, emit;
  logic [CH_W-1:0]  rd_ch, scan_ch;
  logic [MEM_W-1:0] acc_sum, scan_val;
  logic             acc_ovf;

  assign acc_ready = (state_q == ST_IDLE);
  assign ch_ok     = int'(acc_ch) < N_CH;
  assign rd_ch     = ch_ok ? acc_ch : '0;
  assign wr_en     = acc_valid && acc_ready && ch_ok;

  inf_accum #(.MEM_W(MEM_W), .W_W(W_W)) u_accum (
    .mem_i    (mem_q[rd_ch]),
    .weight_i (acc_weight),
    .sum_o    (acc_sum),
    .ovf_o    (acc_ovf)
  );

  assign last_beat = (out_ch_q == CH_W'(N_CH-1));
  assign emit      = ((state_q == ST_IDLE) && scan_start) || ((state_q == ST_SCAN) && !last_beat);
  assign scan_ch   = (state_q == ST_SCAN && !last_beat) ? out_ch_q + CH_W'(1) : '0;
  // Bypass so an event accepted on the scan_start edge is seen by beat 0.
  assign scan_val  = (wr_en && acc_ch == scan_ch) ? acc_sum : mem_q[scan_ch];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (scan_start) state_d = ST_SCAN;
      ST_SCAN: if (last_beat)  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (clr) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      for (int i = 0; i < N_CH; i++) mem_q[i] <= '0;
      of_q        <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_mem_q   <= '0;
      win_valid_q <= 1'b0;
      win_ch_q    <= '0;
      win_mem_q   <= '0;
      best_ch_q   <= '0;
      best_mem_q  <= '0;
    end else begin
      out_valid_q <= 1'b0;
      win_valid_q <= 1'b0;
      busy_q      <= (state_d != ST_IDLE);
      if (wr_en) begin
        mem_q[rd_ch] <= acc_sum;
        if (acc_ovf) of_q[rd_ch] <= 1'b1;
      end
      if (emit) begin
        out_valid_q <= 1'b1;
        out_ch_q    <= scan_ch;
        out_mem_q   <= scan_val;
        // Beat 0 seeds the running max; strict compare keeps ties at low index.
        if (state_q == ST_IDLE || $signed(scan_val) > $signed(best_mem_q)) begin
          best_ch_q  <= scan_ch;
          best_mem_q <= scan_val;
        end
      end
      if (state_q == ST_SCAN && last_beat) begin
        win_valid_q <= 1'b1;
        win_ch_q    <= best_ch_q;
        win_mem_q   <= best_mem_q;
      end
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_mem   = out_mem_q;
  assign win_valid = win_valid_q;
  assign win_ch    = win_ch_q;
  assign win_mem   = win_mem_q;
  assign of_mask   = of_q;

endmodule

// File: tb/tb_inf_neuron_array.sv
module tb_inf_neuron_array;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n, clr, acc_valid, scan_start;
  logic [1:0]  acc_ch;
  logic [7:0]  acc_weight;
  logic        acc_ready, busy, out_valid, win_valid;
  logic [1:0]  out_ch, win_ch;
  logic [15:0] out_mem, win_mem;
  logic [3:0]  of_mask;

  // Second instance with a non-power-of-two count, so out-of-range channels exist.
  logic        b_clr, b_acc_valid, b_scan_start;
  logic [2:0]  b_acc_ch;
  logic [7:0]  b_acc_weight;
  logic        b_acc_ready, b_busy, b_out_valid, b_win_valid;
  logic [2:0]  b_out_ch, b_win_ch;
  logic [15:0] b_out_mem, b_win_mem;
  logic [4:0]  b_of_mask;

  always #5 clk = ~clk;

  inf_neuron_array #(.N_CH(N), .MEM_W(16), .W_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_ch(acc_ch), .acc_weight(acc_weight),
    .scan_start(scan_start), .busy(busy),
    .out_valid(out_valid), .out_ch(out_ch), .out_mem(out_mem),
    .win_valid(win_valid), .win_ch(win_ch), .win_mem(win_mem), .of_mask(of_mask)
  );

  inf_neuron_array #(.N_CH(5), .MEM_W(16), .W_W(8)) dut5 (
    .clk(clk), .rst_n(rst_n), .clr(b_clr),
    .acc_valid(b_acc_valid), .acc_ready(b_acc_ready), .acc_ch(b_acc_ch), .acc_weight(b_acc_weight),
    .scan_start(b_scan_start), .busy(b_busy),
    .out_valid(b_out_valid), .out_ch(b_out_ch), .out_mem(b_out_mem),
    .win_valid(b_win_valid), .win_ch(b_win_ch), .win_mem(b_win_mem), .of_mask(b_of_mask)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: plain integers, range-checked against the 16-bit signed range.
  int       m [N];
  logic [3:0] of_m;
  int       exp_m [N];

  typedef struct {
    int         ch;
    int         w;
    logic [3:0] exp_of;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < N; i++) m[i] = 0;
    of_m = '0;
  endfunction

  function automatic void model_add(input int ch, input int w);
    int s;
    if (ch >= N) return;
    s = m[ch] + w;
    if (s > 32767) begin
      of_m[ch] = 1'b1;
`ifdef INF_SAT_EN
      s = 32767;
`else
      s = s - 65536;
`endif
    end else if (s < -32768) begin
      of_m[ch] = 1'b1;
`ifdef INF_SAT_EN
      s = -32768;
`else
      s = s + 65536;
`endif
    end
    m[ch] = s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input int ch, input int w);
    acc_valid  = 1'b1;
    acc_ch     = 2'(ch);
    acc_weight = 8'(w);
    tick();
    acc_valid  = 1'b0;
    model_add(ch, w);
  endtask

  task automatic do_clr(input bit with_ev, input int ch, input int w);
    clr = 1'b1;
    if (with_ev) begin
      acc_valid  = 1'b1;
      acc_ch     = 2'(ch);
      acc_weight = 8'(w);
    end
    tick();
    clr       = 1'b0;
    acc_valid = 1'b0;
    model_clear();
    chk("clr_out_valid", int'(out_valid), 0);
    chk("clr_busy", int'(busy), 0);
    chk("clr_win_valid", int'(win_valid), 0);
    chk("clr_acc_ready", int'(acc_ready), 1);
    chk("clr_of_mask", int'(of_mask), 0);
    chk("clr_win_mem", int'($signed(win_mem)), 0);
  endtask

  // Full scan with cycle-exact checks. use_model copies the model into exp_m;
  // otherwise exp_m must be preloaded by the caller.
  task automatic do_scan(input bit with_ev, input int ch, input int w,
                         input bit hold2, input bit use_model);
    int best;
    chk("scan_pre_ready", int'(acc_ready), 1);
    scan_start = 1'b1;
    if (with_ev) begin
      acc_valid  = 1'b1;
      acc_ch     = 2'(ch);
      acc_weight = 8'(w);
      model_add(ch, w);
    end
    tick();
    acc_valid = 1'b0;
    if (!hold2) scan_start = 1'b0;
    if (use_model) for (int i = 0; i < N; i++) exp_m[i] = m[i];
    best = 0;
    for (int i = 1; i < N; i++) if (exp_m[i] > exp_m[best]) best = i;
    for (int i = 0; i < N; i++) begin
      chk("beat_valid", int'(out_valid), 1);
      chk("beat_ch", int'(out_ch), i);
      chk("beat_mem", int'($signed(out_mem)), exp_m[i]);
      chk("beat_busy", int'(busy), 1);
      chk("beat_ready", int'(acc_ready), 0);
      chk("beat_win_valid", int'(win_valid), 0);
      tick();
      scan_start = 1'b0;
    end
    chk("done_win_valid", int'(win_valid), 1);
    chk("done_win_ch", int'(win_ch), best);
    chk("done_win_mem", int'($signed(win_mem)), exp_m[best]);
    chk("done_busy", int'(busy), 1);
    chk("done_out_valid", int'(out_valid), 0);
    chk("done_ready", int'(acc_ready), 0);
    tick();
    chk("post_win_valid", int'(win_valid), 0);
    chk("post_busy", int'(busy), 0);
    chk("post_ready", int'(acc_ready), 1);
    chk("post_win_hold", int'(win_ch), best);
    chk("post_of_mask", int'(of_mask), int'(of_m));
  endtask

  initial begin
    int seen, got, wch, wmem, nz;
    tbl[0] = '{ch: 2, w: 100, exp_of: 4'b0000};
    tbl[1] = '{ch: 2, w: 100, exp_of: 4'b0000};
    tbl[2] = '{ch: 2, w: 100, exp_of: 4'b0000};
    tbl[3] = '{ch: 1, w: -5,  exp_of: 4'b0000};

    rst_n = 1'b0; clr = 1'b0; acc_valid = 1'b0; scan_start = 1'b0;
    acc_ch = '0; acc_weight = '0;
    b_clr = 1'b0; b_acc_valid = 1'b0; b_scan_start = 1'b0; b_acc_ch = '0; b_acc_weight = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    chk("rst_acc_ready", int'(acc_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    chk("rst_out_mem", int'(out_mem), 0);
    chk("rst_win_valid", int'(win_valid), 0);
    chk("rst_win_ch", int'(win_ch), 0);
    chk("rst_win_mem", int'(win_mem), 0);
    chk("rst_of_mask", int'(of_mask), 0);

    exp_m = '{0, 0, 0, 0};
    do_scan(0, 0, 0, 0, 0);

    // Directed table: back-to-back accumulation on one channel.
    for (int i = 0; i < 4; i++) begin
      ev(tbl[i].ch, tbl[i].w);
      chk("tbl_of_mask", int'(of_mask), int'(tbl[i].exp_of));
    end
    exp_m = '{0, -5, 300, 0};
    do_scan(0, 0, 0, 0, 0);

    // Positive overflow on ch0.
    do_clr(0, 0, 0);
    repeat (259) ev(0, 127);
    chk("ovf0_of_mask", int'(of_mask), 4'b0001);
`ifdef INF_SAT_EN
    exp_m = '{32767, 0, 0, 0};
`else
    exp_m = '{-32643, 0, 0, 0};
`endif
    do_scan(0, 0, 0, 0, 0);

    // Negative overflow on ch3.
    do_clr(0, 0, 0);
    repeat (257) ev(3, -128);
    chk("ovf3_bit", int'(of_mask[3]), 1);
    chk("ovf3_of_mask", int'(of_mask), 4'b1000);
`ifdef INF_SAT_EN
    exp_m = '{0, 0, 0, -32768};
`else
    exp_m = '{0, 0, 0, 32640};
`endif
    do_scan(0, 0, 0, 0, 0);

    // Tie goes to the lower index; scan_start held into SCAN is ignored.
    do_clr(0, 0, 0);
    ev(3, 50);
    ev(1, 50);
    exp_m = '{0, 50, 0, 50};
    do_scan(0, 0, 0, 1, 0);

    // Event on the scan_start edge is included (ch0 exercises the bypass).
    do_scan(1, 0, 77, 0, 1);

    // Event accepted together with clr is discarded.
    do_clr(1, 2, 60);
    exp_m = '{0, 0, 0, 0};
    do_scan(0, 0, 0, 0, 0);

    // clr during the second beat aborts the scan without a winner.
    ev(2, 100);
    ev(0, 20);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    tick();
    chk("abort_beat2_ch", int'(out_ch), 1);
    chk("abort_beat2_valid", int'(out_valid), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_clear();
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(acc_ready), 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (win_valid) seen++;
      tick();
    end
    chk("abort_no_win", seen, 0);
    exp_m = '{0, 0, 0, 0};
    do_scan(0, 0, 0, 0, 0);

    // Randomized traffic against the model.
    for (int it = 0; it < 400; it++) begin
      int r, ch, w;
      r  = int'($urandom_range(0, 39));
      ch = int'($urandom_range(0, N-1));
      w  = int'($urandom_range(0, 255)) - 128;
      if (r == 0) begin
        do_clr(($urandom_range(0, 1) == 1), ch, w);
      end else if (r < 4) begin
        do_scan(($urandom_range(0, 1) == 1), ch, w, ($urandom_range(0, 1) == 1), 1);
      end else begin
        ev(ch, w);
        chk("rnd_of_mask", int'(of_mask), int'(of_m));
      end
    end
    do_scan(0, 0, 0, 0, 1);

    // Out-of-range channels (5..7) on the 5-channel instance are consumed and ignored.
    for (int c = 5; c < 8; c++) begin
      b_acc_valid  = 1'b1;
      b_acc_ch     = 3'(c);
      b_acc_weight = 8'd100;
      chk("oor_ready", int'(b_acc_ready), 1);
      tick();
    end
    b_acc_ch     = 3'd4;
    b_acc_weight = 8'd9;
    tick();
    b_acc_valid  = 1'b0;
    b_scan_start = 1'b1;
    tick();
    b_scan_start = 1'b0;
    got = 0; wch = -1; wmem = -1; nz = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      if (b_out_valid && b_out_ch != 3'd4 && b_out_mem != 16'd0) nz++;
      if (b_win_valid) begin
        got  = 1;
        wch  = int'(b_win_ch);
        wmem = int'($signed(b_win_mem));
      end
      tick();
    end
    chk("oor_win_seen", got, 1);
    chk("oor_win_ch", wch, 4);
    chk("oor_win_mem", wmem, 9);
    chk("oor_other_mem_zero", nz, 0);
    chk("oor_of_mask", int'(b_of_mask), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
